// File: rtl/bp_pkg.sv
// Shared definitions for the gshare fetch predictor: opcodes, instruction kinds,
// 2-bit saturating counter helpers. Defines the default `XLEN when the build does not.
`ifndef XLEN
`define XLEN 32
`endif

package bp_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    INST_OTHER  = 2'd0,
    INST_BRANCH = 2'd1,
    INST_JAL    = 2'd2,
    INST_JALR   = 2'd3
  } inst_kind_e;

  typedef logic [1:0] ctr_t;

  // Weakly not-taken
  localparam ctr_t CTR_RESET = 2'b01;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bp_gshare_if.sv
// Fetch lookup, execute resolve and prediction signals of the gshare predictor.
// slave = predictor side, master = fetch/execute side.
interface bp_gshare_if #(
  parameter int GHR_BITS = 8
);
  logic                 if_valid;
  logic                 if_stall;
  logic [`XLEN-1:0]     if_pc;
  logic [31:0]          if_inst;
  logic                 ex_valid;
  logic [`XLEN-1:0]     ex_pc;
  logic                 ex_is_cond;
  logic                 ex_taken;
  logic [`XLEN-1:0]     ex_target;
  logic [GHR_BITS-1:0]  ex_ghr;
  logic                 ex_mispredict;
  logic                 bp_taken;
  logic [`XLEN-1:0]     bp_npc;
  logic [GHR_BITS-1:0]  bp_ghr;
  logic                 bp_hit;

  modport master (
    output if_valid, if_stall, if_pc, if_inst,
    output ex_valid, ex_pc, ex_is_cond, ex_taken, ex_target, ex_ghr, ex_mispredict,
    input  bp_taken, bp_npc, bp_ghr, bp_hit
  );

  modport slave (
    input  if_valid, if_stall, if_pc, if_inst,
    input  ex_valid, ex_pc, ex_is_cond, ex_taken, ex_target, ex_ghr, ex_mispredict,
    output bp_taken, bp_npc, bp_ghr, bp_hit
  );
endinterface

// File: rtl/bp_ras.sv
// Circular return address stack. A push when full overwrites the oldest entry;
// a pop when empty is ignored; push+pop together replaces the top.
module bp_ras #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] stack_r [DEPTH];
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    top_ptr_s;
  logic [PW:0]      count_r;

  assign top_ptr_s = ptr_r - PW'(1);
  assign top       = stack_r[top_ptr_s];
  assign empty     = (count_r == {(PW+1){1'b0}});

  // Stack storage, write pointer and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r   <= {PW{1'b0}};
      count_r <= {(PW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push && pop && !empty) begin
      stack_r[top_ptr_s] <= push_data;
    end else if (push) begin
      stack_r[ptr_r] <= push_data;
      ptr_r          <= ptr_r + PW'(1);
      if (count_r != FULL) begin
        count_r <= count_r + (PW+1)'(1);
      end
    end else if (pop && !empty) begin
      ptr_r   <= top_ptr_s;
      count_r <= count_r - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/bp_gshare.sv
// Gshare direction predictor with tagged BTB for indirect jumps.
// Define BP_RAS_EN to add a return address stack for call/return prediction.
module bp_gshare
  import bp_pkg::*;
#(
  parameter int GHR_BITS     = 8,
  parameter int PHT_ENTRIES  = 256,
  parameter int BTB_ENTRIES  = 64,
  parameter int BTB_TAG_BITS = 10,
  parameter int RAS_DEPTH    = 8
) (
  input  logic      clock,
  input  logic      reset,
  bp_gshare_if.slave bp
);
  localparam int XLEN     = `XLEN;
  localparam int BTB_IDX  = $clog2(BTB_ENTRIES);
  localparam int TAG_LO   = BTB_IDX + 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [GHR_BITS-1:0]     ghr_r, ghr_next_s;
  ctr_t                    pht_r [PHT_ENTRIES];
  logic                    btb_valid_r [BTB_ENTRIES];
  logic [BTB_TAG_BITS-1:0] btb_tag_r [BTB_ENTRIES];
  logic [XLEN-1:0]         btb_target_r [BTB_ENTRIES];

  logic [GHR_BITS-1:0]     pht_idx_s, train_idx_s;
  logic [BTB_IDX-1:0]      btb_rd_idx_s, btb_wr_idx_s;
  logic                    btb_hit_s, fetch_fire_s, taken_s;
  logic [XLEN-1:0]         pc_plus4_s, b_imm_s, j_imm_s, npc_s;
  inst_kind_e              kind_s;
  logic                    ras_hit_s;
  logic [XLEN-1:0]         ras_top_s;
  logic                    unused_ex_pc_s;

  assign pht_idx_s    = bp.if_pc[GHR_BITS+1:2] ^ ghr_r;
  assign train_idx_s  = bp.ex_pc[GHR_BITS+1:2] ^ bp.ex_ghr;
  assign btb_rd_idx_s = bp.if_pc[BTB_IDX+1:2];
  assign btb_wr_idx_s = bp.ex_pc[BTB_IDX+1:2];
  assign btb_hit_s    = btb_valid_r[btb_rd_idx_s] &&
                        (btb_tag_r[btb_rd_idx_s] == bp.if_pc[TAG_LO+BTB_TAG_BITS-1:TAG_LO]);
  assign fetch_fire_s = bp.if_valid && !bp.if_stall;
  assign pc_plus4_s   = bp.if_pc + PC_STEP;
  assign b_imm_s = {{(XLEN-13){bp.if_inst[31]}}, bp.if_inst[31], bp.if_inst[7],
                    bp.if_inst[30:25], bp.if_inst[11:8], 1'b0};
  assign j_imm_s = {{(XLEN-21){bp.if_inst[31]}}, bp.if_inst[31], bp.if_inst[19:12],
                    bp.if_inst[20], bp.if_inst[30:21], 1'b0};
  assign unused_ex_pc_s = ^bp.ex_pc;

  // Instruction class from the opcode field
  always_comb begin
    kind_s = INST_OTHER;
    case (bp.if_inst[6:0])
      OP_BRANCH: kind_s = INST_BRANCH;
      OP_JAL:    kind_s = INST_JAL;
      OP_JALR:   kind_s = INST_JALR;
      default:   kind_s = INST_OTHER;
    endcase
  end

`ifdef BP_RAS_EN
  logic [4:0] rd_s, rs1_s;
  logic       is_call_s, is_ret_s, ras_empty_s;

  assign rd_s      = bp.if_inst[11:7];
  assign rs1_s     = bp.if_inst[19:15];
  assign is_call_s = ((kind_s == INST_JAL) || (kind_s == INST_JALR)) && is_link(rd_s);
  assign is_ret_s  = (kind_s == INST_JALR) && is_link(rs1_s) && (rd_s == 5'd0);
  assign ras_hit_s = is_ret_s && !ras_empty_s;

  bp_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (XLEN)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (fetch_fire_s && is_call_s),
    .pop       (fetch_fire_s && is_ret_s),
    .push_data (pc_plus4_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  assign ras_hit_s = 1'b0;
  assign ras_top_s = {XLEN{1'b0}};
`endif

  // Zero-latency direction and target lookup
  always_comb begin
    taken_s = 1'b0;
    npc_s   = pc_plus4_s;
    if (bp.if_valid) begin
      case (kind_s)
        INST_BRANCH: begin
          taken_s = pht_r[pht_idx_s][1];
          if (taken_s) npc_s = bp.if_pc + b_imm_s;
          else         npc_s = pc_plus4_s;
        end
        INST_JAL: begin
          taken_s = 1'b1;
          npc_s   = bp.if_pc + j_imm_s;
        end
        INST_JALR: begin
          if (ras_hit_s) begin
            taken_s = 1'b1;
            npc_s   = ras_top_s;
          end else if (btb_hit_s) begin
            taken_s = 1'b1;
            npc_s   = btb_target_r[btb_rd_idx_s];
          end else begin
            taken_s = 1'b0;
            npc_s   = pc_plus4_s;
          end
        end
        default: begin
          taken_s = 1'b0;
          npc_s   = pc_plus4_s;
        end
      endcase
    end else begin
      taken_s = 1'b0;
      npc_s   = pc_plus4_s;
    end
  end

  assign bp.bp_taken = taken_s;
  assign bp.bp_npc   = npc_s;
  assign bp.bp_ghr   = ghr_r;
  assign bp.bp_hit   = btb_hit_s;

  // History: resolve-time repair takes priority over the speculative shift
  always_comb begin
    ghr_next_s = ghr_r;
    if (bp.ex_valid && bp.ex_mispredict) begin
      if (bp.ex_is_cond) ghr_next_s = {bp.ex_ghr[GHR_BITS-2:0], bp.ex_taken};
      else               ghr_next_s = bp.ex_ghr;
    end else if (fetch_fire_s && (kind_s == INST_BRANCH)) begin
      ghr_next_s = {ghr_r[GHR_BITS-2:0], taken_s};
    end else begin
      ghr_next_s = ghr_r;
    end
  end

  // Global history register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ghr_r <= {GHR_BITS{1'b0}};
    else       ghr_r <= ghr_next_s;
  end

  // Direction counters trained at resolve with the carried history snapshot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_r[i] <= CTR_RESET;
    end else if (bp.ex_valid && bp.ex_is_cond) begin
      pht_r[train_idx_s] <= bp.ex_taken ? ctr_inc(pht_r[train_idx_s])
                                        : ctr_dec(pht_r[train_idx_s]);
    end
  end

  // BTB fill for taken unconditional jumps; conflicts overwrite
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_r[i]  <= 1'b0;
        btb_tag_r[i]    <= {BTB_TAG_BITS{1'b0}};
        btb_target_r[i] <= {XLEN{1'b0}};
      end
    end else if (bp.ex_valid && bp.ex_taken && !bp.ex_is_cond) begin
      btb_valid_r[btb_wr_idx_s]  <= 1'b1;
      btb_tag_r[btb_wr_idx_s]    <= bp.ex_pc[TAG_LO+BTB_TAG_BITS-1:TAG_LO];
      btb_target_r[btb_wr_idx_s] <= bp.ex_target;
    end
  end
endmodule

// File: doc/bp_gshare.md
Name: bp_gshare

Overview:
- Next-generation fetch-stage branch predictor; replaces the single-mode predictor.
- Gshare direction prediction: global history XOR PC indexes a 2-bit counter PHT.
- Target prediction: direct-mapped tagged BTB for indirect jumps, decoded immediates for direct branches and jumps, optional return address stack.
- Sits beside the fetch/instruction-buffer boundary. Lookup is combinational from registered state; training comes from the execute-stage resolve port.

Parameters:
GHR_BITS, 8, global history length; PHT index width = GHR_BITS
PHT_ENTRIES, 256, direction counters; must equal 2**GHR_BITS
BTB_ENTRIES, 64, direct-mapped BTB entries, power of two
BTB_TAG_BITS, 10, stored tag width, taken from PC bits above the index
RAS_DEPTH, 8, return stack entries, power of two

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
if_valid  in  1  fetch slot holds a valid instruction
if_stall  in  1  fetch held; no speculative state update this cycle
if_pc  in  `XLEN  PC of fetched instruction
if_inst  in  32  fetched instruction word
ex_valid  in  1  resolve packet valid
ex_pc  in  `XLEN  PC of resolved control instruction
ex_is_cond  in  1  resolved instruction is a conditional branch
ex_taken  in  1  actual direction
ex_target  in  `XLEN  actual target
ex_ghr  in  GHR_BITS  history snapshot carried with the instruction
ex_mispredict  in  1  direction or target mispredicted; repair history
bp_taken  out  1  predicted taken
bp_npc  out  `XLEN  predicted next PC
bp_ghr  out  GHR_BITS  history snapshot to carry down the pipe
bp_hit  out  1  BTB hit for if_pc

Behaviour:
- Reset, asynchronous: GHR=0; all PHT counters=2'b01 (weakly not-taken); BTB valid bits=0; RAS pointer and count=0.
- Outputs after reset: bp_taken=0 except JAL; bp_npc=if_pc+4; bp_ghr=0; bp_hit=0.
- if_valid=0: bp_taken=0, bp_npc=if_pc+4; no state change.
- Lookup, 0-cycle latency:
  - idx = if_pc[GHR_BITS+1:2] ^ GHR.
  - bp_ghr = GHR before this instruction's update.
  - BTB index = if_pc[log2(BTB_ENTRIES)+1:2]; bp_hit = valid && tag match.
- Prediction by decoded opcode:
  - Conditional branch: taken = PHT[idx][1]; target = if_pc + B-imm.
  - JAL: taken=1; target = if_pc + J-imm.
  - JALR: taken = bp_hit; target = BTB target. Return (RAS enabled) overrides this: see Optional Feature.
  - Not taken or other instruction: bp_npc = if_pc+4.
- Speculative history: on if_valid && !if_stall && conditional branch, GHR <= {GHR[GHR_BITS-2:0], bp_taken}.
- Repair: on ex_valid && ex_mispredict:
  - Conditional: GHR <= {ex_ghr[GHR_BITS-2:0], ex_taken}.
  - Otherwise: GHR <= ex_ghr.
  - Repair beats a same-cycle speculative update.
- PHT training: on ex_valid && ex_is_cond, counter at ex_pc[GHR_BITS+1:2]^ex_ghr increments if taken, else decrements; saturates at 0 and 3.
- BTB training: on ex_valid && ex_taken && !ex_is_cond, write valid, tag and ex_target; overwrite on conflict.
- Same-cycle read and write to the same PHT/BTB entry: lookup returns the old value (no bypass).
- Reset asserted mid-operation clears all state immediately; partial updates are discarded.
- All PC arithmetic is modulo 2^`XLEN.

Optional Feature:
- Macro: BP_RAS_EN.
- With the macro defined:
  - Call = JAL/JALR with rd in {x1,x5}: on if_valid && !if_stall, push if_pc+4.
  - Return = JALR with rs1 in {x1,x5}, rd=x0: pop; predict taken to top of stack when count>0, else fall back to BTB.
  - Push when full overwrites the oldest entry (pointer wraps, count saturates at RAS_DEPTH).
  - Pop when empty is a no-op.
  - RAS is not repaired on mispredict.
- Without the macro: no RAS storage; returns are predicted by BTB only.

Decomposition:
- Shared package (bp_pkg): opcode constants for BRANCH/JAL/JALR; link-register check function; 2-bit saturating counter typedef with inc/dec functions; counter reset constant 2'b01.
- One sub-module, bp_ras: circular stack with push/pop/top/empty; instantiated only under BP_RAS_EN.

Test Plan:
1. Reset, then if_pc=0x100 with BEQ imm=+16 -> bp_taken=0, bp_npc=0x104, bp_ghr=0.
2. Resolve that BEQ taken twice (ex_ghr=0), then fetch with GHR=0 -> counter 3, bp_taken=1, bp_npc=0x110.
3. JALR at 0x200 resolved taken to 0x800, then refetch 0x200 -> bp_hit=1, bp_taken=1, bp_npc=0x800.
4. Three predicted-taken branches (GHR=0x07), then ex_mispredict with ex_ghr=0x01, ex_taken=0 -> GHR=0x02 next cycle; a same-cycle fetch branch is ignored.
5. BP_RAS_EN: JAL x1 at 0x300, then RET -> bp_npc=0x304. Nine calls with depth 8, then nine returns -> eighth return predicts the second call's return address; ninth falls back to BTB.
6. Assert reset while ex_valid is high -> PHT counter stays 2'b01 and BTB valid=0 after release.
